apb_add_master: RTL and testbench

// - APB (AMBA3-style, no PSLVERR/PSTRB) single-target master for a read-increment-write flow.
// - Command add_i=01: read one word from TARGET_ADDR and hold it in an internal data register.
// - Command add_i=11: write (held word + INCR) back to TARGET_ADDR.
// - Sits between a local control source and one APB slave.
// - Generates the SETUP and ACCESS phases and honours PREADY wait states.

---
 rtl/apb_add_master.sv | 136 +++++++++++++
 tb/tb_apb_add_master.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/apb_add_master.sv
// APB master for a single-target read-increment-write flow.
// A read captures one word from TARGET_ADDR; a write returns that word plus INCR.
module apb_add_master #(
  parameter int                 ADDR_W      = 32,
  parameter int                 DATA_W      = 32,
  parameter logic [ADDR_W-1:0]  TARGET_ADDR = 32'hA000,
  parameter logic [DATA_W-1:0]  INCR        = 32'd1
) (
  input  logic              pclk,
  input  logic              preset_n,
  input  logic [1:0]        add_i,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  output logic              psel,
  output logic              penable,
  output logic [ADDR_W-1:0] paddr,
  output logic              pwrite,
  output logic [DATA_W-1:0] pwdata
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SETUP  = 2'b01,
    ST_ACCESS = 2'b10
  } state_t;

  localparam logic [1:0] CMD_READ  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b11;

  state_t              state_q, state_d;
  logic                psel_q, psel_d;
  logic                penable_q, penable_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic                pwrite_q, pwrite_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  // Increment wraps modulo 2^DATA_W by construction of the adder width.
  function automatic logic [DATA_W-1:0] next_word(input logic [DATA_W-1:0] word);
    return word + INCR;
  endfunction

  // Next-state and next-output decode; every APB output is registered.
  always_comb begin
    state_d   = state_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    paddr_d   = paddr_q;
    pwrite_d  = pwrite_q;
    pwdata_d  = pwdata_q;
    rdata_d   = rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (add_i == CMD_READ) begin
          state_d   = ST_SETUP;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          paddr_d   = TARGET_ADDR;
          pwrite_d  = 1'b0;
          pwdata_d  = {DATA_W{1'b0}};
        end else if (add_i == CMD_WRITE) begin
          state_d   = ST_SETUP;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          paddr_d   = TARGET_ADDR;
          pwrite_d  = 1'b1;
          pwdata_d  = next_word(rdata_q);
        end else begin
          state_d   = ST_IDLE;
        end
      end

      ST_SETUP: begin
        state_d   = ST_ACCESS;
        penable_d = 1'b1;
      end

      ST_ACCESS: begin
        // Address, direction and data stay frozen across wait states.
        if (pready) begin
          state_d   = ST_IDLE;
          psel_d    = 1'b0;
          penable_d = 1'b0;
          paddr_d   = {ADDR_W{1'b0}};
          pwrite_d  = 1'b0;
          pwdata_d  = {DATA_W{1'b0}};
          if (!pwrite_q) begin
            rdata_d = prdata;
          end else begin
            rdata_d = rdata_q;
          end
        end else begin
          state_d = ST_ACCESS;
        end
      end

      default: begin
        state_d   = ST_IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
        paddr_d   = {ADDR_W{1'b0}};
        pwrite_d  = 1'b0;
        pwdata_d  = {DATA_W{1'b0}};
      end
    endcase
  end

  // State, output and data registers; reset aborts any in-flight transfer.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_q   <= ST_IDLE;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      paddr_q   <= {ADDR_W{1'b0}};
      pwrite_q  <= 1'b0;
      pwdata_q  <= {DATA_W{1'b0}};
      rdata_q   <= {DATA_W{1'b0}};
    end else begin
      state_q   <= state_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      paddr_q   <= paddr_d;
      pwrite_q  <= pwrite_d;
      pwdata_q  <= pwdata_d;
      rdata_q   <= rdata_d;
    end
  end

  assign psel    = psel_q;
  assign penable = penable_q;
  assign paddr   = paddr_q;
  assign pwrite  = pwrite_q;
  assign pwdata  = pwdata_q;

endmodule

// File: tb/tb_apb_add_master.sv
// Directed bench for apb_add_master: reset, read, write, wrap, wait states,
// ignored commands and mid-transfer reset.
module tb_apb_add_master;

  logic        pclk;
  logic        preset_n;
  logic [1:0]  add_i;
  logic [31:0] prdata;
  logic        pready;
  logic        psel;
  logic        penable;
  logic [31:0] paddr;
  logic        pwrite;
  logic [31:0] pwdata;

  int total;
  int bad;

  apb_add_master dut (
    .pclk     (pclk),
    .preset_n (preset_n),
    .add_i    (add_i),
    .prdata   (prdata),
    .pready   (pready),
    .psel     (psel),
    .penable  (penable),
    .paddr    (paddr),
    .pwrite   (pwrite),
    .pwdata   (pwdata)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // Bus snapshot: {psel, penable, pwrite, paddr, pwdata}
  function automatic logic [66:0] bus(input logic s, input logic e, input logic w,
                                      input logic [31:0] a, input logic [31:0] d);
    return {s, e, w, a, d};
  endfunction

  task automatic check(input string tag, input logic [66:0] obs, input logic [66:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  logic [66:0] idle_bus;
  logic [66:0] obs_bus;

  always_comb obs_bus = {psel, penable, pwrite, paddr, pwdata};

  initial begin
    total    = 0;
    bad      = 0;
    idle_bus = bus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    preset_n = 1'b0;
    add_i    = 2'b00;
    prdata   = 32'h0;
    pready   = 1'b0;

    // Reset for two cycles, then idle with no command
    tick();
    tick();
    check("reset_outputs", obs_bus, idle_bus);
    check("reset_rdata", {35'h0, dut.rdata_q}, 67'h0);
    preset_n = 1'b1;
    tick();
    tick();
    check("idle_no_cmd", obs_bus, idle_bus);

    // Read returning 5, one wait state
    add_i = 2'b01;
    tick();
    add_i = 2'b00;
    check("rd_setup", obs_bus, bus(1'b1, 1'b0, 1'b0, 32'hA000, 32'h0));
    tick();
    check("rd_access", obs_bus, bus(1'b1, 1'b1, 1'b0, 32'hA000, 32'h0));
    tick();
    check("rd_access_wait", obs_bus, bus(1'b1, 1'b1, 1'b0, 32'hA000, 32'h0));
    prdata = 32'h5;
    pready = 1'b1;
    tick();
    pready = 1'b0;
    prdata = 32'h0;
    check("rd_done_idle", obs_bus, idle_bus);
    check("rd_rdata_5", {35'h0, dut.rdata_q}, {35'h0, 32'h5});

    // Write of 5+1; pready high during SETUP must be ignored and held one extra cycle after
    add_i = 2'b11;
    tick();
    add_i  = 2'b00;
    pready = 1'b1;
    check("wr_setup", obs_bus, bus(1'b1, 1'b0, 1'b1, 32'hA000, 32'h6));
    tick();
    check("wr_access", obs_bus, bus(1'b1, 1'b1, 1'b1, 32'hA000, 32'h6));
    tick();
    check("wr_done_idle", obs_bus, idle_bus);
    check("wr_rdata_kept", {35'h0, dut.rdata_q}, {35'h0, 32'h5});
    tick();
    pready = 1'b0;
    check("pready_extra_ignored", obs_bus, idle_bus);

    // Read all-ones then write wraps to zero
    add_i = 2'b01;
    tick();
    add_i = 2'b00;
    tick();
    prdata = 32'hFFFF_FFFF;
    pready = 1'b1;
    tick();
    pready = 1'b0;
    check("rd_ff_rdata", {35'h0, dut.rdata_q}, {35'h0, 32'hFFFF_FFFF});
    add_i = 2'b11;
    tick();
    add_i = 2'b00;
    check("wrap_setup", obs_bus, bus(1'b1, 1'b0, 1'b1, 32'hA000, 32'h0));
    tick();
    pready = 1'b1;
    tick();
    pready = 1'b0;
    check("wrap_done", obs_bus, idle_bus);

    // Read with three wait states; a write pulse during ACCESS is ignored
    add_i = 2'b01;
    tick();
    add_i = 2'b00;
    tick();
    for (int i = 0; i < 3; i++) begin
      if (i == 1) add_i = 2'b11;
      else        add_i = 2'b00;
      check($sformatf("wait_stable_%0d", i), obs_bus, bus(1'b1, 1'b1, 1'b0, 32'hA000, 32'h0));
      tick();
    end
    add_i = 2'b00;
    check("wait_still_access", obs_bus, bus(1'b1, 1'b1, 1'b0, 32'hA000, 32'h0));
    prdata = 32'h10;
    pready = 1'b1;
    tick();
    pready = 1'b0;
    prdata = 32'h0;
    check("wait_done_idle", obs_bus, idle_bus);
    check("wait_rdata_10", {35'h0, dut.rdata_q}, {35'h0, 32'h10});
    tick();
    check("no_queued_write", obs_bus, idle_bus);

    // Reserved command stays idle
    add_i = 2'b10;
    tick();
    add_i = 2'b00;
    check("reserved_cmd_1", obs_bus, idle_bus);
    tick();
    check("reserved_cmd_2", obs_bus, idle_bus);

    // Reset during ACCESS of a read returning 9
    add_i = 2'b01;
    tick();
    add_i = 2'b00;
    tick();
    check("rst_pre_access", obs_bus, bus(1'b1, 1'b1, 1'b0, 32'hA000, 32'h0));
    prdata   = 32'h9;
    pready   = 1'b1;
    preset_n = 1'b0;
    #1;
    check("rst_async_outputs", obs_bus, idle_bus);
    check("rst_async_rdata", {35'h0, dut.rdata_q}, 67'h0);
    tick();
    pready   = 1'b0;
    prdata   = 32'h0;
    preset_n = 1'b1;
    tick();
    check("rst_release_idle", obs_bus, idle_bus);
    check("rst_rdata_discarded", {35'h0, dut.rdata_q}, 67'h0);

    // Write before any read after reset sends INCR
    add_i = 2'b11;
    tick();
    add_i = 2'b00;
    check("fresh_write_setup", obs_bus, bus(1'b1, 1'b0, 1'b1, 32'hA000, 32'h1));
    tick();
    pready = 1'b1;
    tick();
    pready = 1'b0;
    check("fresh_write_done", obs_bus, idle_bus);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
